// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: fetches one 8-word line over a BIU burst, then writes it once.
// Define ICACHE_CRIT_WORD_FWD_EN to forward the missing (critical) word as soon as it arrives.
module icache_refill_ctrl #(
    parameter int unsigned IDX_W      = 7,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      miss_req_i,
    input  logic [31:0]               miss_addr_i,
    output logic                      miss_ack_o,
    input  logic                      flush_i,
    output logic                      biu_cyc_o,
    output logic                      biu_stb_o,
    output logic                      biu_cab_o,
    output logic                      biu_we_o,
    output logic [3:0]                biu_sel_o,
    output logic [31:0]               biu_adr_o,
    input  logic [31:0]               biu_dat_i,
    input  logic                      biu_ack_i,
    input  logic                      biu_err_i,
    output logic                      refill_we_o,
    output logic [IDX_W-1:0]          refill_idx_o,
    output logic [32-5-IDX_W-1:0]     refill_tag_o,
    output logic [32*LINE_WORDS-1:0]  refill_line_o,
    output logic                      refill_done_o,
    output logic                      refill_err_o,
    output logic                      busy_o,
    output logic                      fwd_valid_o,
    output logic [31:0]               fwd_data_o
);

    typedef enum logic [1:0] {StIdle, StBurst, StWrite} state_e;

    state_e                    r_state;
    logic [2:0]                r_cnt;
    logic [2:0]                r_crit;
    logic [26:0]               r_line_addr;
    logic                      r_kill;
    logic                      r_ack;
    logic                      r_cyc;
    logic                      r_stb;
    logic                      r_cab;
    logic                      r_we_bus;
    logic [3:0]                r_sel;
    logic [31:0]               r_adr;
    logic                      r_refill_we;
    logic                      r_done;
    logic                      r_err;
    logic                      r_busy;
    logic [32*LINE_WORDS-1:0]  r_line;
    logic                      w_unused;

`ifdef ICACHE_CRIT_WORD_FWD_EN
    logic                      r_fwd_valid;
    logic [31:0]               r_fwd_data;
    assign fwd_valid_o = r_fwd_valid;
    assign fwd_data_o  = r_fwd_data;
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_data_o  = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= 3'd0;
            r_crit      <= 3'd0;
            r_line_addr <= '0;
            r_kill      <= 1'b0;
            r_ack       <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_cab       <= 1'b0;
            r_we_bus    <= 1'b0;
            r_sel       <= 4'hF;
            r_adr       <= 32'h0;
            r_refill_we <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_line      <= '0;
`ifdef ICACHE_CRIT_WORD_FWD_EN
            r_fwd_valid <= 1'b0;
            r_fwd_data  <= 32'h0;
`endif
        end else begin
            r_ack       <= 1'b0;
            r_refill_we <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef ICACHE_CRIT_WORD_FWD_EN
            r_fwd_valid <= 1'b0;
`endif
            unique case (r_state)
                StIdle: begin
                    r_kill <= 1'b0;
                    if (miss_req_i) begin
                        r_ack       <= 1'b1;
                        r_state     <= StBurst;
                        r_busy      <= 1'b1;
                        r_cyc       <= 1'b1;
                        r_stb       <= 1'b1;
                        r_cab       <= 1'b1;
                        r_adr       <= {miss_addr_i[31:5], 5'b0};
                        r_line_addr <= miss_addr_i[31:5];
                        r_crit      <= miss_addr_i[4:2];
                        r_cnt       <= 3'd0;
                    end
                end
                StBurst: begin
                    if (flush_i) r_kill <= 1'b1;
                    // Error beats terminate immediately; any ack in the same cycle is ignored.
                    if (biu_err_i) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_cab   <= 1'b0;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_kill  <= 1'b0;
                        r_cnt   <= 3'd0;
                        r_state <= StIdle;
                    end else if (biu_ack_i) begin
                        r_line[{r_cnt, 5'b0} +: 32] <= biu_dat_i;
                        r_cnt      <= r_cnt + 3'd1;
                        r_adr[4:2] <= r_cnt + 3'd1;
`ifdef ICACHE_CRIT_WORD_FWD_EN
                        if (r_cnt == r_crit && !r_kill) begin
                            r_fwd_valid <= 1'b1;
                            r_fwd_data  <= biu_dat_i;
                        end
`endif
                        if (r_cnt == 3'd7) begin
                            r_cyc       <= 1'b0;
                            r_stb       <= 1'b0;
                            r_cab       <= 1'b0;
                            r_refill_we <= ~(r_kill | flush_i);
                            r_done      <= 1'b1;
                            r_state     <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    r_busy  <= 1'b0;
                    r_kill  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign miss_ack_o    = r_ack;
    assign biu_cyc_o     = r_cyc;
    assign biu_stb_o     = r_stb;
    assign biu_cab_o     = r_cab;
    assign biu_we_o      = r_we_bus;
    assign biu_sel_o     = r_sel;
    assign biu_adr_o     = r_adr;
    assign refill_we_o   = r_refill_we;
    assign refill_idx_o  = r_line_addr[IDX_W-1:0];
    assign refill_tag_o  = r_line_addr[26:IDX_W];
    assign refill_line_o = r_line;
    assign refill_done_o = r_done;
    assign refill_err_o  = r_err;
    assign busy_o        = r_busy;
    assign w_unused      = ^{miss_addr_i[1:0], r_crit};

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameter IDX_W, default 7, cache set-index width; tag width = 32-5-IDX_W.
REQ-002 Parameter LINE_WORDS, default 8, 32-bit words per line; only 8 supported.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 miss_req_i  in  1  fetch miss request, held high until miss_ack_o.
REQ-006 miss_addr_i  in  32  missing fetch address.
REQ-007 miss_ack_o  out  1  one-cycle pulse: request accepted.
REQ-008 flush_i  in  1  invalidate in-flight refill.
REQ-009 biu_cyc_o, biu_stb_o, biu_cab_o, biu_we_o  out  1 each  BIU request controls.
REQ-010 biu_sel_o  out  4  byte selects; biu_adr_o  out  32  burst address.
REQ-011 biu_dat_i  in  32  read data; biu_ack_i, biu_err_i  in  1 each  BIU terminations.
REQ-012 refill_we_o  out  1  line write strobe to data/tag arrays.
REQ-013 refill_idx_o  out  IDX_W  set index; refill_tag_o  out  32-5-IDX_W  tag.
REQ-014 refill_line_o  out  256  assembled line, word 0 at [31:0].
REQ-015 refill_done_o, refill_err_o, busy_o  out  1 each  status.
REQ-016 fwd_valid_o  out  1; fwd_data_o  out  32  critical-word forward (see Configuration).

Function
REQ-017 States: IDLE, BURST, WRITE; all outputs registered.
REQ-018 IDLE with miss_req_i=1: next cycle miss_ack_o=1, state BURST, biu_cyc/stb/cab=1, biu_we=0, biu_sel=4'hF, biu_adr={miss_addr_i[31:5],5'b0}; line address latched.
REQ-019 BURST: 3-bit word counter starts 0; each biu_ack_i stores biu_dat_i into word[counter], increments counter and biu_adr_o[4:2].
REQ-020 Ack with counter==7: next cycle cyc/stb/cab=0, state WRITE; no ack-less data capture.
REQ-021 WRITE: refill_we_o=1 and refill_done_o=1 for exactly one cycle, then IDLE; min miss-to-write latency = 10 cycles with back-to-back acks.
REQ-022 refill_line_o, refill_idx_o, refill_tag_o stable from WRITE until next miss_ack_o.
REQ-023 biu_err_i in BURST: next cycle cyc/stb/cab=0, refill_err_o=1 one cycle, state IDLE, no refill_we_o; ack and err same cycle -> err wins.
REQ-024 flush_i in BURST: sticky kill flag set; burst completes normally; WRITE suppresses refill_we_o, still pulses refill_done_o.
REQ-025 flush_i in IDLE or WRITE: no effect on current write; kill flag cleared on entering IDLE.
REQ-026 miss_req_i while busy_o=1: ignored, not acked; busy_o=1 in BURST and WRITE.
REQ-027 Counter wraps 7->0 only on the last ack; biu_adr_o[31:5] never changes within a burst.

Reset
REQ-028 rst=1 at posedge: state IDLE, all 1-bit outputs 0, biu_sel_o=4'hF, biu_adr_o=0, refill_line_o=0, counter=0, kill flag=0.
REQ-029 rst mid-burst: cyc/stb dropped next cycle, no refill_we_o, partial data discarded.

Configuration
REQ-030 Macro ICACHE_CRIT_WORD_FWD_EN defined: ack of word index miss_addr[4:2] drives fwd_valid_o=1 one cycle next cycle with fwd_data_o=that word, unless kill flag set.
REQ-031 Macro undefined: fwd_valid_o=0 and fwd_data_o=0 constantly; fetch waits for refill_done_o.

Verification
REQ-032 miss_addr_i=32'h0000_1234, acks every cycle with data 0x10..0x17 -> biu_adr_o 0x1220..0x123C, refill_line_o[31:0]=0x10, [255:224]=0x17, refill_idx_o=7'h11, one refill_we_o.
REQ-033 Same miss, biu_err_i on 3rd beat -> cyc drops next cycle, refill_err_o pulse, refill_we_o never asserted.
REQ-034 flush_i pulse on 2nd beat -> 8 beats complete, refill_done_o=1, refill_we_o=0.
REQ-035 ICACHE_CRIT_WORD_FWD_EN defined, miss_addr_i=32'h0000_1214, word5=0xCAFE_F00D -> fwd_valid_o one cycle after 6th ack, fwd_data_o=0xCAFE_F00D.
REQ-036 rst asserted after 4th ack, then new miss 32'h0000_2000 -> clean burst from 0x2000, counter starts 0.
REQ-037 Acks with 2-cycle gaps, miss_req_i held during BURST -> single miss_ack_o, line correct.
